int_to_single_arbiter: RTL and testbench

//  Round-robin arbiter sharing one int_to_single converter among N_REQ requesters.

---
 rtl/int_to_single_arbiter.sv | 175 +++++++++++++++++
 tb/tb_int_to_single_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_single_arbiter.sv
// Round-robin arbiter sharing one int_to_single converter among N_REQ requesters.
// One transaction at a time: grant, forward the integer, wait for the result, return it.
module int_to_single_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*N_REQ-1:0]   req_int,
  input  logic [N_REQ-1:0]      req_stb,
  output logic [N_REQ-1:0]      req_ack,
  output logic [31:0]           res_val,
  output logic [N_REQ-1:0]      res_stb,
  input  logic [N_REQ-1:0]      res_ack,
  output logic [IDW-1:0]        res_id,
  output logic [31:0]           cvt_int_val,
  output logic                  cvt_int_stb,
  input  logic                  cvt_int_ack,
  input  logic [31:0]           cvt_single_val,
  input  logic                  cvt_single_stb,
  output logic                  cvt_single_ack,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SEND, S_WAIT, S_RETURN} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     res_id_q, res_id_d;
  logic [31:0]        res_val_q, res_val_d;
  logic [31:0]        cvt_int_val_q, cvt_int_val_d;
  logic [N_REQ-1:0]   req_ack_q, req_ack_d;
  logic [N_REQ-1:0]   res_stb_q, res_stb_d;
  logic               cvt_int_stb_q, cvt_int_stb_d;
  logic               cvt_single_ack_q, cvt_single_ack_d;
  logic               busy_q, busy_d;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDW-1:0]     pick_off;
  logic [IDW:0]       pick_sum;
  logic [IDW-1:0]     pick_id;
  logic               pick_valid;
  logic [N_REQ-1:0]   g_onehot;
  logic               req_stb_g;
  logic               res_ack_g;
  logic [31:0]        req_int_g;
  logic [IDW-1:0]     ptr_next;

  // Rotating the request vector by ptr makes "first set bit at or after ptr" a plain LSB search.
  assign req_dbl = {req_stb, req_stb} >> ptr_q;
  assign req_rot = req_dbl[N_REQ-1:0];

  always_comb begin
    pick_valid = |req_rot;
    pick_off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = IDW'(k);
    end
    pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
    if (pick_sum >= (IDW+1)'(N_REQ)) pick_sum = pick_sum - (IDW+1)'(N_REQ);
    pick_id = pick_sum[IDW-1:0];
  end

  assign g_onehot  = N_REQ'(1) << grant_q;
  assign req_stb_g = |(req_stb & g_onehot);
  assign res_ack_g = |(res_ack & g_onehot);
  assign ptr_next  = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    req_int_g = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == IDW'(i)) req_int_g = req_int[32*i +: 32];
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    grant_d          = grant_q;
    res_id_d         = res_id_q;
    res_val_d        = res_val_q;
    cvt_int_val_d    = cvt_int_val_q;
    req_ack_d        = req_ack_q;
    res_stb_d        = res_stb_q;
    cvt_int_stb_d    = cvt_int_stb_q;
    cvt_single_ack_d = cvt_single_ack_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_id;
          req_ack_d = N_REQ'(1) << pick_id;
          state_d   = S_GRANT;
        end
      end
      S_GRANT: begin
        req_ack_d = '0;
        if (req_stb_g) begin
          cvt_int_val_d = req_int_g;
          cvt_int_stb_d = 1'b1;
          state_d       = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (cvt_int_stb_q && cvt_int_ack) begin
          cvt_int_stb_d    = 1'b0;
          cvt_single_ack_d = 1'b1;
          state_d          = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cvt_single_stb && cvt_single_ack_q) begin
          res_val_d        = cvt_single_val;
          res_id_d         = grant_q;
          cvt_single_ack_d = 1'b0;
          res_stb_d        = g_onehot;
          state_d          = S_RETURN;
        end
      end
      S_RETURN: begin
        // The served requester drops to lowest priority once its result is taken.
        if (res_ack_g) begin
          res_stb_d = '0;
          ptr_d     = ptr_next;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      ptr_q            <= '0;
      grant_q          <= '0;
      res_id_q         <= '0;
      res_val_q        <= '0;
      cvt_int_val_q    <= '0;
      req_ack_q        <= '0;
      res_stb_q        <= '0;
      cvt_int_stb_q    <= 1'b0;
      cvt_single_ack_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      grant_q          <= grant_d;
      res_id_q         <= res_id_d;
      res_val_q        <= res_val_d;
      cvt_int_val_q    <= cvt_int_val_d;
      req_ack_q        <= req_ack_d;
      res_stb_q        <= res_stb_d;
      cvt_int_stb_q    <= cvt_int_stb_d;
      cvt_single_ack_q <= cvt_single_ack_d;
      busy_q           <= busy_d;
    end
  end

  assign req_ack        = req_ack_q;
  assign res_val        = res_val_q;
  assign res_stb        = res_stb_q;
  assign res_id         = res_id_q;
  assign cvt_int_val    = cvt_int_val_q;
  assign cvt_int_stb    = cvt_int_stb_q;
  assign cvt_single_ack = cvt_single_ack_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_int_to_single_arbiter.sv
// Bench for int_to_single_arbiter: random requesters, a converter model with random latency,
// and a round-robin reference built from queues of served requesters.
module tb_int_to_single_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [32*N-1:0]   req_int;
  logic [N-1:0]      req_stb, req_ack, res_stb, res_ack;
  logic [31:0]       res_val, cvt_int_val, cvt_single_val;
  logic [IDW-1:0]    res_id, grant_id;
  logic              cvt_int_stb, cvt_int_ack, cvt_single_stb, cvt_single_ack, busy;

  int totalChecks  = 0;
  int passedChecks = 0;
  int failedChecks = 0;

  logic [N-1:0]  pending;
  logic [31:0]   value [N];
  bit            heldMode;
  int            ptrModel;
  int            served [$];
  logic [31:0]   lastResVal [$];

  int_to_single_arbiter #(.N_REQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_int(req_int), .req_stb(req_stb), .req_ack(req_ack),
    .res_val(res_val), .res_stb(res_stb), .res_ack(res_ack), .res_id(res_id),
    .cvt_int_val(cvt_int_val), .cvt_int_stb(cvt_int_stb), .cvt_int_ack(cvt_int_ack),
    .cvt_single_val(cvt_single_val), .cvt_single_stb(cvt_single_stb),
    .cvt_single_ack(cvt_single_ack), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // IEEE-754 single from a signed integer, round to nearest even.
  function automatic logic [31:0] toSingle(input logic [31:0] v);
    logic [63:0] a, m, rem, half;
    int msb, sh;
    logic s;
    if (v == 32'd0) return 32'd0;
    s = v[31];
    a = {32'd0, s ? (~v + 32'd1) : v};
    msb = 0;
    for (int i = 0; i < 32; i++) if (a[i]) msb = i;
    if (msb <= 23) begin
      m = a << (23 - msb);
    end else begin
      sh   = msb - 23;
      m    = a >> sh;
      rem  = a & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 64'd1;
      if (m[24]) begin
        m   = m >> 1;
        msb = msb + 1;
      end
    end
    return {s, 8'(127 + msb), m[22:0]};
  endfunction

  function automatic int pickNext(input logic [N-1:0] pend, input int p);
    for (int k = 0; k < N; k++) begin
      if (pend[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] newValue();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalChecks++;
    assert (obs === exp) begin
      passedChecks++;
    end else begin
      failedChecks++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) req_int[32*i +: 32] = value[i];
    req_stb = pending;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ack"}, req_ack, 0);
    checkOutput({tag, "_res_stb"}, res_stb, 0);
    checkOutput({tag, "_res_val"}, res_val, 0);
    checkOutput({tag, "_res_id"}, res_id, 0);
    checkOutput({tag, "_grant_id"}, grant_id, 0);
    checkOutput({tag, "_cvt_int_val"}, cvt_int_val, 0);
    checkOutput({tag, "_cvt_int_stb"}, cvt_int_stb, 0);
    checkOutput({tag, "_cvt_single_ack"}, cvt_single_ack, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    pending = '0;
    res_ack = '0;
    applyStimulus();
    @(negedge clk);
    checkResetState("reset_pulse");
    rst = 1'b0;
    ptrModel = 0;
  endtask

  // Serve nTxn transactions; after each result appears, the owner withholds res_ack for stall cycles.
  task automatic serveLoop(input int nTxn, input int stall);
    int done = 0, cyc = 0, expId = 0, stallLeft = 0;
    int maxCyc = 40 * nTxn + 40;
    bit granted = 0, accepted = 0, resSeen = 0, takenLast;
    logic [31:0] inflight = '0, heldVal = '0;
    logic [N-1:0] accSnap = '0, takeSnap = '0, ownerMask = '0, r;
    while (done < nTxn && cyc < maxCyc) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (accSnap[i]) begin
          accepted = 1;
          inflight = value[i];
          if (heldMode) value[i] = newValue();
          else pending[i] = 1'b0;
        end
      end
      takenLast = 0;
      if (|takeSnap) begin
        done++;
        served.push_back(expId);
        lastResVal.push_back(heldVal);
        ptrModel = (expId + 1) % N;
        granted = 0; accepted = 0; resSeen = 0; takenLast = 1;
      end
      if (takenLast) checkOutput("busy_gap", busy, 0);
      if (!granted && req_ack != '0) begin
        expId = pickNext(pending, ptrModel);
        ownerMask = (expId >= 0) ? (N'(1) << expId) : '0;
        checkOutput("grant_onehot", req_ack, ownerMask);
        checkOutput("grant_id", grant_id, expId);
        granted = 1;
      end
      if (accepted && !resSeen && res_stb != '0) begin
        checkOutput("res_stb", res_stb, ownerMask);
        checkOutput("res_id", res_id, expId);
        checkOutput("res_val", res_val, toSingle(inflight));
        checkOutput("busy_active", busy, 1);
        heldVal = res_val;
        resSeen = 1;
        stallLeft = stall;
      end else if (resSeen && stallLeft > 0) begin
        checkOutput("hold_res_stb", res_stb, ownerMask);
        checkOutput("hold_res_val", res_val, toSingle(inflight));
        checkOutput("hold_no_grant", req_ack, 0);
      end
      applyStimulus();
      r = N'($urandom);
      if (resSeen && stallLeft > 0) begin
        r = r & ~ownerMask;
        stallLeft--;
      end
      res_ack = r;
      accSnap = req_ack & req_stb;
      takeSnap = res_stb & res_ack;
    end
    if (done < nTxn) checkOutput("serve_timeout", done, nTxn);
    res_ack = '0;
    if (heldMode) pending = '0;
    applyStimulus();
  endtask

  // Converter model: random int_ack and result latency, garbage on the result bus when idle.
  initial begin
    int cs = 0, dly = 0;
    logic [31:0] held = '0;
    cvt_int_ack = 1'b0;
    cvt_single_stb = 1'b0;
    cvt_single_val = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        cs = 0;
        cvt_int_ack = 1'b0;
        cvt_single_stb = 1'b0;
      end else begin
        case (cs)
          0: begin
            cvt_single_val = $urandom;
            if (cvt_int_stb) begin dly = $urandom_range(0, 3); cs = 1; end
          end
          1: if (dly == 0) begin cvt_int_ack = 1'b1; held = cvt_int_val; cs = 2; end else dly--;
          2: begin cvt_int_ack = 1'b0; dly = $urandom_range(0, 4); cs = 3; end
          3: if (dly == 0) begin
               cvt_single_val = toSingle(held);
               cvt_single_stb = 1'b1;
               cs = cvt_single_ack ? 5 : 4;
             end else dly--;
          4: if (cvt_single_ack) cs = 5;
          default: begin cvt_single_stb = 1'b0; cvt_single_val = $urandom; cs = 0; end
        endcase
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, seen;
    rst = 1'b1;
    pending = '0;
    res_ack = '0;
    heldMode = 0;
    for (int i = 0; i < N; i++) value[i] = '0;
    applyStimulus();
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    ptrModel = 0;

    // Single request, then ptr=1 makes requester 2 win over 0.
    served.delete(); lastResVal.delete();
    value[0] = 32'd1; pending = 4'b0001;
    serveLoop(1, 0);
    checkOutput("t1_res_val", lastResVal[0], 32'h3F80_0000);
    value[0] = newValue(); value[2] = newValue(); pending = 4'b0101;
    serveLoop(2, 0);
    checkOutput("t1_ptr_first", served[1], 2);
    checkOutput("t1_ptr_second", served[2], 0);

    // Requesters 0 and 2 together from ptr=0.
    applyReset();
    served.delete(); lastResVal.delete();
    value[0] = 32'hFFFF_FFFF; value[2] = 32'd0; pending = 4'b0101;
    serveLoop(2, 0);
    checkOutput("t2_order0", served[0], 0);
    checkOutput("t2_order1", served[1], 2);
    checkOutput("t2_val0", lastResVal[0], 32'hBF80_0000);
    checkOutput("t2_val1", lastResVal[1], 32'h0000_0000);

    // All requesters held for 8 transactions.
    applyReset();
    served.delete(); lastResVal.delete();
    heldMode = 1;
    for (int i = 0; i < N; i++) value[i] = newValue();
    pending = 4'b1111;
    serveLoop(8, 0);
    heldMode = 0;
    for (int i = 0; i < 8; i++) checkOutput("t3_rr_order", served[i], i % N);

    // Requester 1 withdraws while granted; ptr must stay at 1.
    value[0] = newValue(); pending = 4'b0001;
    serveLoop(1, 0);
    @(negedge clk);
    value[1] = newValue(); pending = 4'b0010;
    applyStimulus();
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        checkOutput("t4_grant", req_ack, 4'b0010);
        seen = 1;
        pending = '0;
        applyStimulus();
      end
    end
    checkOutput("t4_grant_seen", seen, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("t4_no_cvt", cvt_int_stb, 0);
    end
    checkOutput("t4_idle", busy, 0);
    checkOutput("t4_req_ack", req_ack, 0);
    served.delete(); lastResVal.delete();
    for (int i = 0; i < 3; i++) value[i] = newValue();
    pending = 4'b0111;
    serveLoop(3, 0);
    checkOutput("t4_after_0", served[0], 1);
    checkOutput("t4_after_1", served[1], 2);
    checkOutput("t4_after_2", served[2], 0);

    // Requester 3 stalls res_ack for 10 cycles while requester 0 waits.
    served.delete(); lastResVal.delete();
    value[3] = newValue(); value[0] = newValue(); pending = 4'b1001;
    serveLoop(2, 10);
    checkOutput("t5_order0", served[0], 3);
    checkOutput("t5_order1", served[1], 0);

    // Reset while waiting on the converter, then a fresh pair of requests.
    @(negedge clk);
    value[2] = newValue(); pending = 4'b0100;
    applyStimulus();
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      @(negedge clk);
      if ((req_ack & 4'b0100) != '0) seen = 1;
    end
    checkOutput("t6_grant_seen", seen, 1);
    @(negedge clk);
    pending = '0;
    applyStimulus();
    seen = 0;
    for (int c = 0; c < 12 && seen == 0; c++) begin
      if (cvt_single_ack) seen = 1;
      else @(negedge clk);
    end
    checkOutput("t6_wait_seen", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("t6_reset");
    rst = 1'b0;
    ptrModel = 0;
    served.delete(); lastResVal.delete();
    value[0] = newValue(); value[2] = newValue(); pending = 4'b0101;
    serveLoop(2, 0);
    checkOutput("t6_fresh0", served[0], 0);
    checkOutput("t6_fresh1", served[1], 2);

    // Random masks, values, holding behaviour and result stalls.
    for (int round = 0; round < 20; round++) begin
      pending = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) value[i] = newValue();
      heldMode = bit'($urandom_range(0, 1));
      n = heldMode ? $urandom_range(1, 6) : $countones(pending);
      serveLoop(n, $urandom_range(0, 3));
      heldMode = 0;
    end

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
